// File: rtl/rv32i_fetch_queue.sv
// rv32i_fetch_queue: sequential instruction prefetcher feeding decode through a DEPTH-entry queue.
// States: IDLE = nothing pending | WAIT = one pending, keep response | DROP = one pending, discard response.
module rv32i_fetch_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [XLEN-1:0]        externalResetVector,
    output logic [XLEN-1:0]        mem_i_addr,
    output logic                   mem_i_rstrb,
    input  logic [31:0]            mem_i_rdata,
    input  logic                   mem_i_rbusy,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_insn,
    output logic [XLEN-1:0]        out_pc,
    output logic [$clog2(DEPTH):0] level,
    output logic                   misalign_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL      = LW'(DEPTH);
    localparam logic [LW-1:0] NEAR_FULL_LVL = LW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q;
    logic [31:0]     insn_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q   [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            misalign_q;

    logic resp_any, resp_keep, room, issue, push, pop;

    assign resp_any  = ((state_q == WAIT) || (state_q == DROP)) && !mem_i_rbusy;
    assign resp_keep = (state_q == WAIT) && !mem_i_rbusy;
    // A response landing this cycle claims a slot before the next request may; pops are not credited.
    assign room  = resp_keep ? (level_q < NEAR_FULL_LVL) : (level_q < FULL_LVL);
    assign issue = rst && !redirect_valid && room && ((state_q == IDLE) || resp_any);
    assign push  = resp_keep && !redirect_valid;
    assign pop   = (level_q != '0) && out_ready && !redirect_valid;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            level_d    = '0;
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (push)  wr_ptr_d   = wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_d   = rd_ptr_q + AW'(1);
            if (push && !pop)      level_d = level_q + LW'(1);
            else if (pop && !push) level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= externalResetVector;
            req_pc_q   <= externalResetVector;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (issue) req_pc_q <= fetch_pc_q;
            case (state_q)
                IDLE: begin
                    if (issue) state_q <= WAIT;
                end
                WAIT, DROP: begin
                    if (redirect_valid)    state_q <= mem_i_rbusy ? DROP : IDLE;
                    else if (!mem_i_rbusy) state_q <= issue ? WAIT : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            insn_mem_q[wr_ptr_q] <= mem_i_rdata;
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
        end
    end

    assign mem_i_addr   = fetch_pc_q;
    assign mem_i_rstrb  = issue;
    assign out_valid    = (level_q != '0);
    assign out_insn     = insn_mem_q[rd_ptr_q];
    assign out_pc       = pc_mem_q[rd_ptr_q];
    assign level        = level_q;
    assign misalign_err = misalign_q;
endmodule

// File: tb/tb_rv32i_fetch_queue.sv
// Bench for rv32i_fetch_queue: directed scenarios then random traffic against a queue-level reference model.
module tb_rv32i_fetch_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [31:0] vector;
    logic [31:0] mem_i_addr;
    logic        mem_i_rstrb;
    logic [31:0] mem_i_rdata;
    logic        mem_i_rbusy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic [31:0] out_pc;
    logic [2:0]  level;
    logic        misalign_err;

    rv32i_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .externalResetVector (vector),
        .mem_i_addr          (mem_i_addr),
        .mem_i_rstrb         (mem_i_rstrb),
        .mem_i_rdata         (mem_i_rdata),
        .mem_i_rbusy         (mem_i_rbusy),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_insn            (out_insn),
        .out_pc              (out_pc),
        .level               (level),
        .misalign_err        (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc;
    } ent_t;

    // reference model: queue contents, fetch pointer, one outstanding request (kept or discarded)
    ent_t        mq[$];
    logic [31:0] m_fpc;
    logic [31:0] m_req;
    logic        m_out;
    logic        m_keep;
    logic        m_mis;

    // memory environment
    logic        env_pend;
    logic [31:0] env_addr;
    int          env_wait;
    int          fixed_lat;

    logic [31:0] strb_log[$];
    logic [31:0] pop_log[$];

    int n_cmp;
    int n_bad;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_0BAD;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst_v, input logic redir, input logic [31:0] rpc, input logic rdy);
        logic        resp, room, exp_strb, s_strb;
        logic [31:0] s_addr;
        int          occ;
        rst            = rst_v;
        redirect_valid = redir;
        redirect_pc    = rpc;
        out_ready      = rdy;
        mem_i_rbusy    = env_pend ? (env_wait != 0) : 1'($urandom_range(0, 1));
        mem_i_rdata    = env_pend ? mem_word(env_addr) : $urandom;
        #1;
        resp     = m_out && !mem_i_rbusy;
        occ      = mq.size();
        room     = (occ + ((resp && m_keep) ? 1 : 0)) < DEPTH;
        exp_strb = rst_v && !redir && room && (!m_out || resp);
        check("rstrb", 64'(mem_i_rstrb), 64'(exp_strb));
        if (exp_strb) check("addr", 64'(mem_i_addr), 64'(m_fpc));
        check("level", 64'(level), 64'(occ));
        check("out_valid", 64'(out_valid), 64'(occ != 0));
        if (occ != 0) begin
            check("out_insn", 64'(out_insn), 64'(mq[0].insn));
            check("out_pc", 64'(out_pc), 64'(mq[0].pc));
        end
        check("misalign", 64'(misalign_err), 64'(m_mis));
        s_strb = mem_i_rstrb;
        s_addr = mem_i_addr;
        if (s_strb) strb_log.push_back(s_addr);
        if (rst_v && !redir && rdy && out_valid) pop_log.push_back(out_pc);
        @(posedge clk);
        if (!rst_v) begin
            mq.delete();
            m_out  = 1'b0;
            m_keep = 1'b0;
            m_fpc  = vector;
            m_mis  = 1'b0;
        end else if (redir) begin
            mq.delete();
            m_fpc = {rpc[31:2], 2'b00};
            m_mis = (rpc[1:0] != 2'b00);
            if (m_out) begin
                if (resp) m_out  = 1'b0;
                else      m_keep = 1'b0;
            end
        end else begin
            m_mis = 1'b0;
            if (occ != 0 && rdy) void'(mq.pop_front());
            if (resp && m_keep) mq.push_back('{insn: mem_word(m_req), pc: m_req});
            if (resp) m_out = 1'b0;
            if (exp_strb) begin
                m_out  = 1'b1;
                m_keep = 1'b1;
                m_req  = m_fpc;
                m_fpc  = m_fpc + 32'd4;
            end
        end
        if (!rst_v) begin
            env_pend = 1'b0;
        end else begin
            if (env_pend) begin
                if (env_wait == 0) env_pend = 1'b0;
                else               env_wait--;
            end
            if (s_strb) begin
                env_pend = 1'b1;
                env_addr = s_addr;
                env_wait = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            end
        end
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        fixed_lat = 0;
        env_pend = 1'b0;
        env_addr = '0;
        env_wait = 0;
        vector = 32'h100;
        rst = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;
        mem_i_rbusy = 1'b0;
        mem_i_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        m_out = 1'b0; m_keep = 1'b0; m_fpc = vector; m_req = vector; m_mis = 1'b0;
        check("reset_level", 64'(level), 64'd0);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_rstrb", 64'(mem_i_rstrb), 64'd0);

        // 1: zero-wait memory streams one instruction per cycle
        do_reset();
        strb_log.delete(); pop_log.delete();
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);
        check("t1_strb0", 64'(qget(strb_log, 0)), 64'h100);
        check("t1_strb1", 64'(qget(strb_log, 1)), 64'h104);
        check("t1_strb2", 64'(qget(strb_log, 2)), 64'h108);
        check("t1_pop0", 64'(qget(pop_log, 0)), 64'h100);
        check("t1_pop1", 64'(qget(pop_log, 1)), 64'h104);
        check("t1_pop2", 64'(qget(pop_log, 2)), 64'h108);
        check("t1_npop", 64'(pop_log.size()), 64'd6);

        // 2: back-pressure fills the queue, one pop frees exactly one fetch
        do_reset();
        strb_log.delete();
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b0);
        check("t2_nstrb", 64'(strb_log.size()), 64'd4);
        check("t2_last", 64'(qget(strb_log, 3)), 64'h10C);
        check("t2_full", 64'(level), 64'd4);
        strb_log.delete();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (4) step(1'b1, 1'b0, 32'h0, 1'b0);
        check("t2_nstrb_pop", 64'(strb_log.size()), 64'd1);
        check("t2_refill", 64'(qget(strb_log, 0)), 64'h110);
        check("t2_full2", 64'(level), 64'd4);

        // 3: redirect while the first response is still busy
        do_reset();
        strb_log.delete(); pop_log.delete();
        fixed_lat = 3;
        step(1'b1, 1'b0, 32'h0, 1'b1);
        fixed_lat = 0;
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h200, 1'b1);
        check("t3_flush", 64'(level), 64'd0);
        repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1);
        check("t3_strb0", 64'(qget(strb_log, 0)), 64'h100);
        check("t3_strb1", 64'(qget(strb_log, 1)), 64'h200);
        check("t3_pop0", 64'(qget(pop_log, 0)), 64'h200);

        // 4: misaligned redirect target
        step(1'b1, 1'b1, 32'h202, 1'b1);
        check("t4_mis", 64'(misalign_err), 64'd1);
        strb_log.delete();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("t4_mis_clr", 64'(misalign_err), 64'd0);
        check("t4_addr", 64'(qget(strb_log, 0)), 64'h200);

        // 5: fetch address wraps past the top of the address space
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        strb_log.delete();
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
        check("t5_top", 64'(qget(strb_log, 0)), 64'hFFFF_FFFC);
        check("t5_wrap", 64'(qget(strb_log, 1)), 64'h0);

        // 6: reset with a busy request pending and three entries queued
        do_reset();
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
        fixed_lat = 5;
        step(1'b1, 1'b0, 32'h0, 1'b0);
        check("t6_lvl3", 64'(level), 64'd3);
        vector = 32'h340;
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("t6_lvl0", 64'(level), 64'd0);
        check("t6_valid", 64'(out_valid), 64'd0);
        fixed_lat = 0;
        strb_log.delete();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        check("t6_vec", 64'(qget(strb_log, 0)), 64'h340);

        // random traffic: latency, back-pressure, redirects, occasional reset
        fixed_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst;
            logic        r_red;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 299) != 0);
            r_red = ($urandom_range(0, 19) == 0);
            r_pc  = $urandom;
            if ($urandom_range(0, 3) == 0) r_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            if (!r_rst) vector = $urandom & 32'hFFFF_FFFC;
            step(r_rst, r_red, r_pc, ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
